// File: rtl/adc_spi_if.sv
// Serial link between an MCP3008-style ADC master and its device end.
// The master drives sclk/cs_n/din; the device returns dout with a drive enable.
interface adc_spi_if;
  logic sclk;
  logic cs_n;
  logic din;
  logic dout;
  logic dout_oe;

  modport master (
    output sclk,
    output cs_n,
    output din,
    input  dout,
    input  dout_oe
  );

  modport slave (
    input  sclk,
    input  cs_n,
    input  din,
    output dout,
    output dout_oe
  );
endinterface

// File: rtl/adc_spi_responder.sv
// MCP3008/MCP3208-style ADC device model for on-FPGA loopback.
// Oversamples the serial link in the clk domain and shifts back a channel value.
module adc_spi_responder #(
  parameter int RES_BITS    = 10,
  parameter int NUM_CH      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  adc_spi_if.slave                   spi,
  input  logic [NUM_CH*RES_BITS-1:0] ch_data,
  output logic                       conv_strobe,
  output logic [3:0]                 cfg,
  output logic                       busy
);

  localparam int CW = $clog2(NUM_CH);
  localparam int NW = $clog2(RES_BITS + 1);
  localparam int SW = 2 * RES_BITS - 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    CFG,
    SAMPLE,
    NULL_BIT,
    MSB,
    LSB,
    ZERO
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic [NW-1:0]          cnt_q, cnt_d;
  logic [2:0]             sh_q, sh_d;
  logic [SW-1:0]          seq_q, seq_d;
  logic [3:0]             cfg_q, cfg_d;
  logic                   dout_q, dout_d;
  logic                   oe_q, oe_d;
  logic                   strobe_q, strobe_d;
  logic                   busy_q, busy_d;
  logic                   armed_q, armed_d;

  logic                   sclk_s, cs_s, din_s;
  logic                   rise, fall;
  logic [RES_BITS-1:0]    ch [NUM_CH];
  logic [CW-1:0]          pos, neg;
  logic [RES_BITS:0]      diff;
  logic [RES_BITS-1:0]    result;
  logic [SW-1:0]          seq_load;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch[i] = ch_data[i*RES_BITS +: RES_BITS];
    end
  end

  // Differential pairs differ only in D0; NUM_CH=4 drops D2 via CW.
  always_comb begin
    pos    = cfg_q[CW-1:0];
    neg    = pos ^ CW'(1);
    diff   = {1'b0, ch[pos]} - {1'b0, ch[neg]};
    result = ch[pos];
    if (!cfg_q[3]) begin
      result = diff[RES_BITS] ? '0 : diff[RES_BITS-1:0];
    end
    seq_load = '0;
    seq_load[SW-1 -: RES_BITS] = result;
    for (int i = 1; i < RES_BITS; i++) begin
      seq_load[RES_BITS-1-i] = result[i];
    end
  end

  always_comb begin
    sclk_sync_d = SYNC_STAGES'({sclk_sync_q, spi.sclk});
    cs_sync_d   = SYNC_STAGES'({cs_sync_q, spi.cs_n});
    din_sync_d  = SYNC_STAGES'({din_sync_q, spi.din});
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    din_s       = din_sync_q[SYNC_STAGES-1];
    rise        = sclk_s & ~sclk_prev_q;
    fall        = ~sclk_s & sclk_prev_q;
    sclk_prev_d = sclk_s;

    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    seq_d    = seq_q;
    cfg_d    = cfg_q;
    dout_d   = dout_q;
    oe_d     = oe_q;
    strobe_d = 1'b0;
    busy_d   = busy_q;
    armed_d  = armed_q;

    // Deselect beats any sclk edge seen in the same cycle.
    if (state_q != IDLE && cs_s) begin
      state_d = IDLE;
      cnt_d   = '0;
      dout_d  = 1'b0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cs_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            armed_d = 1'b0;
            state_d = WAIT_START;
          end
        end
        WAIT_START: begin
          if (rise && din_s) begin
            busy_d  = 1'b1;
            cnt_d   = '0;
            state_d = CFG;
          end
        end
        CFG: begin
          if (rise) begin
            sh_d = {sh_q[1:0], din_s};
            if (cnt_q == NW'(3)) begin
              cfg_d   = {sh_q, din_s};
              cnt_d   = '0;
              state_d = SAMPLE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        SAMPLE: begin
          if (rise) begin
            state_d = NULL_BIT;
          end
        end
        NULL_BIT: begin
          if (fall) begin
            seq_d    = seq_load;
            strobe_d = 1'b1;
            dout_d   = 1'b0;
            oe_d     = 1'b1;
            cnt_d    = '0;
            state_d  = MSB;
          end
        end
        MSB: begin
          if (fall) begin
            dout_d = seq_q[SW-1];
            seq_d  = {seq_q[SW-2:0], 1'b0};
            if (cnt_q == NW'(RES_BITS - 1)) begin
              cnt_d   = '0;
              state_d = LSB;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        LSB: begin
          if (fall) begin
            dout_d = seq_q[SW-1];
            seq_d  = {seq_q[SW-2:0], 1'b0};
            if (cnt_q == NW'(RES_BITS - 2)) begin
              cnt_d   = '0;
              state_d = ZERO;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ZERO: begin
          if (fall) begin
            dout_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      din_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      cnt_q       <= '0;
      sh_q        <= '0;
      seq_q       <= '0;
      cfg_q       <= '0;
      dout_q      <= 1'b0;
      oe_q        <= 1'b0;
      strobe_q    <= 1'b0;
      busy_q      <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      din_sync_q  <= din_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      seq_q       <= seq_d;
      cfg_q       <= cfg_d;
      dout_q      <= dout_d;
      oe_q        <= oe_d;
      strobe_q    <= strobe_d;
      busy_q      <= busy_d;
      armed_q     <= armed_d;
    end
  end

  assign spi.dout    = dout_q;
  assign spi.dout_oe = oe_q;
  assign conv_strobe = strobe_q;
  assign cfg         = cfg_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: directed and random transfers
// compared against an arithmetic model of the returned bit stream.
module tb_adc_spi_responder;
  localparam int RB   = 10;
  localparam int NC   = 8;
  localparam int SS   = 2;
  localparam int HALF = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [NC*RB-1:0] ch_data;
  logic           conv_strobe;
  logic [3:0]     cfg;
  logic           busy;
  int             vec_cnt = 0;
  int             err_cnt = 0;
  int             strb_cnt = 0;

  adc_spi_if spi ();

  adc_spi_responder #(
    .RES_BITS   (RB),
    .NUM_CH     (NC),
    .SYNC_STAGES(SS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .spi        (spi),
    .ch_data    (ch_data),
    .conv_strobe(conv_strobe),
    .cfg        (cfg),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (conv_strobe === 1'b1) strb_cnt++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int ref_result(input bit sgl, input bit [2:0] d);
    int p, n, a, b;
    p = int'(d);
    n = p ^ 1;
    a = int'(ch_data[p*RB +: RB]);
    b = int'(ch_data[n*RB +: RB]);
    if (sgl) return a;
    return (a - b < 0) ? 0 : a - b;
  endfunction

  // Stream after start: null, MSB-first word, bits 1..RB-1, zeros.
  function automatic bit exp_bit(input int k, input int res);
    if (k == 0) return 1'b0;
    if (k <= RB) return bit'((res >> (RB - k)) & 1);
    if (k <= 2*RB - 1) return bit'((res >> (k - RB)) & 1);
    return 1'b0;
  endfunction

  task automatic xfer(input int lead0, input bit sgl, input bit [2:0] d,
                      input int abort_c, input int rst_c,
                      input int chg_c, input logic [NC*RB-1:0] chg_val);
    int res, s0;
    bit b;
    res = ref_result(sgl, d);
    s0  = strb_cnt;
    spi.cs_n = 1'b0;
    clks(4);
    for (int c = -lead0; c < 30; c++) begin
      if (c == rst_c) begin
        rst = 1'b1;
        clks(1);
        rst = 1'b0;
        check("rst_dout", 32'(spi.dout), 0);
        check("rst_oe", 32'(spi.dout_oe), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_cfg", 32'(cfg), 0);
        check("rst_strobe", 32'(strb_cnt - s0), 0);
        for (int k = 0; k < 4; k++) begin
          spi.din  = 1'b1;
          spi.sclk = 1'b0;
          clks(HALF);
          check("rst_hold_oe", 32'(spi.dout_oe), 0);
          check("rst_hold_busy", 32'(busy), 0);
          spi.sclk = 1'b1;
          clks(HALF);
        end
        spi.sclk = 1'b0;
        spi.cs_n = 1'b1;
        clks(8);
        check("rst_strobe_end", 32'(strb_cnt - s0), 0);
        return;
      end
      if (c < 0) b = 1'b0;
      else if (c == 0) b = 1'b1;
      else if (c == 1) b = sgl;
      else if (c <= 4) b = d[4-c];
      else b = bit'($urandom % 2);
      spi.din  = b;
      spi.sclk = 1'b0;
      if (c == chg_c) ch_data = chg_val;
      clks(HALF);
      if (c >= 6) begin
        check($sformatf("dout[%0d]", c - 6), 32'(spi.dout),
              32'(exp_bit(c - 6, res)));
        check("oe_on", 32'(spi.dout_oe), 1);
      end else begin
        check("oe_off", 32'(spi.dout_oe), 0);
      end
      check("busy", 32'(busy), 32'(c >= 1));
      spi.sclk = 1'b1;
      clks(HALF);
      if (c == abort_c) begin
        spi.sclk = 1'b0;
        spi.cs_n = 1'b1;
        repeat (SS + 1) @(posedge clk);
        #1;
        check("abort_oe", 32'(spi.dout_oe), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_dout", 32'(spi.dout), 0);
        clks(8);
        check("abort_strobe", 32'(strb_cnt - s0), 32'(abort_c >= 6));
        if (abort_c >= 4) check("abort_cfg", 32'(cfg), 32'({sgl, d}));
        return;
      end
    end
    spi.sclk = 1'b0;
    clks(HALF);
    spi.cs_n = 1'b1;
    clks(8);
    check("end_oe", 32'(spi.dout_oe), 0);
    check("end_busy", 32'(busy), 0);
    check("cfg", 32'(cfg), 32'({sgl, d}));
    check("strobe", 32'(strb_cnt - s0), 1);
  endtask

  initial begin
    logic [NC*RB-1:0] tmp;
    rst      = 1'b1;
    spi.sclk = 1'b0;
    spi.cs_n = 1'b1;
    spi.din  = 1'b0;
    ch_data  = '0;
    clks(3);
    check("reset_dout", 32'(spi.dout), 0);
    check("reset_oe", 32'(spi.dout_oe), 0);
    check("reset_strobe", 32'(conv_strobe), 0);
    check("reset_cfg", 32'(cfg), 0);
    check("reset_busy", 32'(busy), 0);
    rst = 1'b0;
    clks(6);

    ch_data[5*RB +: RB] = 10'h2A5;
    xfer(0, 1'b1, 3'b101, -1, -1, -1, '0);

    ch_data[2*RB +: RB] = 10'h3FF;
    xfer(5, 1'b1, 3'b010, -1, -1, -1, '0);

    ch_data[0 +: RB]  = 10'd100;
    ch_data[RB +: RB] = 10'd300;
    xfer(0, 1'b0, 3'b001, -1, -1, -1, '0);
    xfer(0, 1'b0, 3'b000, -1, -1, -1, '0);

    ch_data[6*RB +: RB] = 10'h3C3;
    xfer(0, 1'b1, 3'b110, 10, -1, -1, '0);
    ch_data[0 +: RB] = 10'h001;
    xfer(0, 1'b1, 3'b000, -1, -1, -1, '0);

    ch_data[3*RB +: RB] = 10'h155;
    xfer(1, 1'b1, 3'b011, -1, 3, -1, '0);
    xfer(0, 1'b1, 3'b011, -1, -1, -1, '0);

    tmp = ch_data;
    tmp[3*RB +: RB] = 10'h2AA;
    xfer(0, 1'b1, 3'b011, -1, -1, 8, tmp);

    for (int i = 0; i < 20; i++) begin
      for (int ch = 0; ch < NC; ch++) begin
        ch_data[ch*RB +: RB] = RB'($urandom_range(0, (1 << RB) - 1));
      end
      xfer(int'($urandom_range(0, 3)), bit'($urandom % 2),
           3'($urandom % 8), -1, -1, -1, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
- Behavioural-synthesizable responder for the MCP3008-style serial ADC protocol used by our Pmod_ADC boards. It is the device end of the link that our ADC front-end drives.
- It oversamples the master's AD_CLK, CS and DIN in the `clk` domain and decodes the start bit and configuration bits.
- It returns the selected channel value on DOUT: first a null bit, then MSB-first data, then LSB-first data.
- Used for on-FPGA loopback testing of the ADC master and the 7-seg display path without a physical ADC fitted.

Parameters:
- RES_BITS, 10, conversion width (10 = MCP3008, 12 = MCP3208).
- NUM_CH, 8, number of analog channels. Only 4 or 8 are legal.
- SYNC_STAGES, 2, synchronizer flops on sclk, cs_n and din.

Ports:
- clk, input, 1, system clock. Must be at least 8x the sclk frequency.
- rst, input, 1, synchronous reset, active-high.
- sclk, input, 1, serial clock from the ADC master (AD_CLK). Asynchronous to clk.
- cs_n, input, 1, chip select, active low. Asynchronous to clk.
- din, input, 1, serial data from the master. Asynchronous to clk.
- ch_data, input, NUM_CH*RES_BITS, packed channel values. CH0 is in the LSBs.
- dout, output, 1, serial data to the master. Registered.
- dout_oe, output, 1, drive enable for dout. When 0, the pad is tri-stated at the top level.
- conv_strobe, output, 1, one-clk pulse when the sample is latched.
- cfg, output, 4, last accepted {SGL, D2, D1, D0}.
- busy, output, 1, high from start-bit detection until cs_n deasserts.

Behaviour:
- Clock and reset: one clock (`clk`). Synchronous, active-high reset (`rst`).
- Reset values: dout=0, dout_oe=0, conv_strobe=0, cfg=4'b0000, busy=0, state=IDLE, all counters 0.
- Input sampling:
  - sclk, cs_n and din each pass through SYNC_STAGES flops.
  - Edges of sclk are detected by comparing against one further flop.
  - Latency from a pin edge to the registered dout/dout_oe update is SYNC_STAGES+1 clk cycles.
- States:
  - IDLE: cs_n high. dout_oe=0. Go to WAIT_START when synchronized cs_n goes low.
  - WAIT_START: on each sclk rising edge, sample din. din=0 stays in this state, so leading zeros are ignored. din=1 sets busy=1 and goes to CFG.
  - CFG: capture din on 4 rising edges, in order SGL, D2, D1, D0. After the 4th edge, update cfg and go to SAMPLE.
  - SAMPLE: the first falling edge is ignored. Wait for the next rising edge, then go to the null-bit phase on the following falling edge.
  - NULL: on that falling edge:
    - latch the result and pulse conv_strobe for 1 clk;
    - set dout=0 and dout_oe=1;
    - go to MSB.
  - MSB: on each of the next RES_BITS falling edges, dout = result bit RES_BITS-1 down to 0. Then go to LSB.
  - LSB: on each of the next RES_BITS-1 falling edges, dout = result bit 1 up to RES_BITS-1. Then go to ZERO.
  - ZERO: dout=0 on every falling edge while cs_n stays low.
- Result computation:
  - Single-ended (SGL=1): result = ch_data slice {D2,D1,D0}.
  - Differential (SGL=0): pos = {D2,D1,D0}, neg = {D2,D1,~D0}. result = ch[pos]-ch[neg], clamped to 0 if negative, computed RES_BITS+1 wide.
  - NUM_CH=4: D2 is ignored and treated as 0.
  - ch_data is sampled only at the NULL falling edge. Changes at any other time do not affect an ongoing transfer.
- cs_n deassertion (synchronized) in any state:
  - next clk: state=IDLE, dout_oe=0, dout=0, busy=0;
  - no conv_strobe is issued if the transfer is still before NULL;
  - cfg keeps its value from the last complete CFG phase.
- Simultaneous cs_n rise and sclk edge in the same clk: cs_n wins and the sclk edge is discarded.
- rst mid-transfer: immediate return to the reset values. A new transfer requires cs_n to be observed high and then low again.
- Back-to-back transfers: a cs_n high pulse of at least SYNC_STAGES+2 clk cycles is required between transfers. Shorter pulses are undefined.

Test Plan:
- Single-ended channel 5:
  - Stimulus: ch_data CH5=10'h2A5, din stream 1,1,1,0,1.
  - Required: cfg=4'b1101, one conv_strobe, dout = null 0, then 1010100101, then LSB-first 010010101, then 0s.
- Leading zeros:
  - Stimulus: 5 zero clocks before the start bit, CH2=10'h3FF.
  - Required: busy rises only at the start bit, dout gives 0 then ten 1s.
- Differential, code 001:
  - Stimulus: CH0=100, CH1=300, cfg 0001.
  - Required: result 200 = 10'b0011001000.
  - Repeat with code 000: result clamps to 0.
- cs_n abort:
  - Stimulus: cs_n rises after B6 has been output.
  - Required: dout_oe=0 within SYNC_STAGES+1 clk. The next transfer on CH0=10'h001 returns the correct value.
- Reset mid-CFG:
  - Stimulus: rst asserted after D2.
  - Required: all outputs at reset values, no conv_strobe.
  - After cs_n is cycled, a full transfer succeeds.
- ch_data stability:
  - Stimulus: change CH3 from 10'h155 to 10'h2AA during the MSB phase.
  - Required: dout continues to shift out 10'h155.
